ulpi_link_tx: RTL and testbench

Link-side ULPI transmit and register-access engine: drives the 8-bit ULPI bus toward the PHY during link-owned cycles, for PHY register writes/reads and USB packet transmission. It is the outbound counterpart of the sniffer's ULPI receive path. It sits in `top_core` beside the receive logic, shares the 60 MHz PHY clock, and owns `ulpi_data_o` and `ulpi_stp_o`.

---
 rtl/ulpi_pkg.sv | 27 ++
 rtl/ulpi_link_tx.sv | 203 ++++++++++++++++++++
 tb/tb_ulpi_link_tx.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_pkg.sv
// Shared definitions for the ULPI link transmit engine: command prefixes,
// FSM state encoding and the bus idle byte.
package ulpi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_REG_WDATA,
        ST_REG_STP,
        ST_RD_TURN,
        ST_RD_DATA,
        ST_TX_DATA,
        ST_TX_STP,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] PFX_TX   = 2'b01;
    localparam logic [1:0] PFX_REGW = 2'b10;
    localparam logic [1:0] PFX_REGR = 2'b11;

    localparam logic [7:0] NOOP = 8'h00;

    function automatic logic [7:0] mk_cmd(input logic [1:0] pfx, input logic [5:0] payload);
        return {pfx, payload};
    endfunction

endpackage

// File: rtl/ulpi_link_tx.sv
// Link-side ULPI transmit / register-access engine. Owns ulpi_data_o and
// ulpi_stp_o during link cycles; all outputs registered except tx_ready_o.
//
// state      | meaning
// IDLE       | bus idle (0x00); start on bus-free, register request first
// CMD        | command byte held until nxt
// REG_WDATA  | write data held until nxt
// REG_STP    | stp + ack for a register write
// RD_TURN    | waiting for PHY to take the bus (dir=1)
// RD_DATA    | capture read data, ack
// TX_DATA    | packet bytes, accepted while nxt & ~dir
// TX_STP     | stp closing a packet
// DRAIN      | PHY aborted the packet; discard through tx_last_i
module ulpi_link_tx
    import ulpi_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic       ulpi_stp_o,
    input  logic       reg_req_i,
    input  logic       reg_we_i,
    input  logic [5:0] reg_addr_i,
    input  logic [7:0] reg_wdata_i,
    output logic       reg_ack_o,
    output logic [7:0] reg_rdata_o,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_last_i,
    output logic       tx_ready_o,
    output logic       tx_err_o
);

    state_t     state_q, state_d;
    logic       dir_q;
    logic [7:0] data_q, data_d;
    logic       stp_q, stp_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic [7:0] rdata_q, rdata_d;
    logic [1:0] kind_q, kind_d;
    logic       last_q, last_d;
    logic       bus_free;

    // Requiring dir low for two consecutive cycles guarantees the turnaround.
    assign bus_free = ~ulpi_dir_i & ~dir_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b1;
            data_q  <= NOOP;
            stp_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
            kind_q  <= PFX_TX;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= ulpi_dir_i;
            data_q  <= data_d;
            stp_q   <= stp_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            kind_q  <= kind_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        stp_d      = 1'b0;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        kind_d     = kind_q;
        last_d     = last_q;
        tx_ready_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                data_d = NOOP;
                if (bus_free) begin
                    if (reg_req_i) begin
                        kind_d  = reg_we_i ? PFX_REGW : PFX_REGR;
                        data_d  = mk_cmd(reg_we_i ? PFX_REGW : PFX_REGR, reg_addr_i);
                        last_d  = 1'b0;
                        state_d = ST_CMD;
                    end else if (tx_valid_i) begin
                        tx_ready_o = 1'b1;
                        kind_d     = PFX_TX;
                        data_d     = mk_cmd(PFX_TX, {2'b00, tx_data_i[3:0]});
                        last_d     = tx_last_i;
                        state_d    = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                if (ulpi_dir_i) begin
                    // Register requests stay pending and retry; a packet has lost its PID.
                    data_d = NOOP;
                    if (kind_q == PFX_TX) begin
                        err_d   = 1'b1;
                        state_d = last_q ? ST_IDLE : ST_DRAIN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (ulpi_nxt_i) begin
                    case (kind_q)
                        PFX_REGW: begin
                            data_d  = reg_wdata_i;
                            state_d = ST_REG_WDATA;
                        end
                        PFX_REGR: begin
                            data_d  = NOOP;
                            state_d = ST_RD_TURN;
                        end
                        default: begin
                            if (last_q) begin
                                data_d  = NOOP;
                                stp_d   = 1'b1;
                                state_d = ST_TX_STP;
                            end else begin
                                state_d = ST_TX_DATA;
                            end
                        end
                    endcase
                end
            end
            ST_REG_WDATA: begin
                if (ulpi_dir_i) begin
                    data_d  = NOOP;
                    state_d = ST_IDLE;
                end else if (ulpi_nxt_i) begin
                    data_d  = NOOP;
                    stp_d   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_REG_STP;
                end
            end
            ST_REG_STP: begin
                data_d  = NOOP;
                state_d = ST_IDLE;
            end
            ST_RD_TURN: begin
                if (ulpi_dir_i) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                rdata_d = ulpi_data_i;
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            ST_TX_DATA: begin
                if (ulpi_dir_i) begin
                    data_d  = NOOP;
                    err_d   = 1'b1;
                    state_d = last_q ? ST_IDLE : ST_DRAIN;
                end else if (last_q) begin
                    // Last byte is on the bus this cycle; stp follows.
                    data_d  = NOOP;
                    stp_d   = 1'b1;
                    state_d = ST_TX_STP;
                end else begin
                    tx_ready_o = ulpi_nxt_i;
                    if (ulpi_nxt_i && tx_valid_i) begin
                        data_d = tx_data_i;
                        last_d = tx_last_i;
                    end
                end
            end
            ST_TX_STP: begin
                data_d  = NOOP;
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                tx_ready_o = 1'b1;
                data_d     = NOOP;
                if (tx_valid_i && tx_last_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                data_d  = NOOP;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ulpi_data_o = data_q;
    assign ulpi_stp_o  = stp_q;
    assign reg_ack_o   = ack_q;
    assign reg_rdata_o = rdata_q;
    assign tx_err_o    = err_q;

endmodule

// File: tb/tb_ulpi_link_tx.sv
// Cycle-scripted bench for ulpi_link_tx: each scripted cycle pushes the
// expected outputs, a negedge monitor pops and compares them.
module tb_ulpi_link_tx;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [7:0] ulpi_data_i = 8'h00;
    logic [7:0] ulpi_data_o;
    logic       ulpi_dir_i = 1'b0;
    logic       ulpi_nxt_i = 1'b0;
    logic       ulpi_stp_o;
    logic       reg_req_i = 1'b0;
    logic       reg_we_i = 1'b0;
    logic [5:0] reg_addr_i = 6'h00;
    logic [7:0] reg_wdata_i = 8'h00;
    logic       reg_ack_o;
    logic [7:0] reg_rdata_o;
    logic       tx_valid_i = 1'b0;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_last_i = 1'b0;
    logic       tx_ready_o;
    logic       tx_err_o;

    ulpi_link_tx dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ulpi_data_i (ulpi_data_i),
        .ulpi_data_o (ulpi_data_o),
        .ulpi_dir_i  (ulpi_dir_i),
        .ulpi_nxt_i  (ulpi_nxt_i),
        .ulpi_stp_o  (ulpi_stp_o),
        .reg_req_i   (reg_req_i),
        .reg_we_i    (reg_we_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_ack_o   (reg_ack_o),
        .reg_rdata_o (reg_rdata_o),
        .tx_valid_i  (tx_valid_i),
        .tx_data_i   (tx_data_i),
        .tx_last_i   (tx_last_i),
        .tx_ready_o  (tx_ready_o),
        .tx_err_o    (tx_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [63:0] tag;
        logic [11:0] exp;
        logic        rchk;
        logic [7:0]  rexp;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic chk(input logic [63:0] tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %0s: got %03h expected %03h", tag, got, exp);
    endtask

    // Packed expectation: {data, stp, ack, err, ready}
    function automatic logic [11:0] ex(input logic [7:0] d, input logic s, input logic a,
                                       input logic e, input logic r);
        return {d, s, a, e, r};
    endfunction

    // One cycle: after the edge, apply dir/nxt and queue what the outputs must show.
    task automatic cyc(input logic [63:0] tag, input logic d, input logic n,
                       input logic [11:0] e, input logic rc, input logic [7:0] re);
        sb_t item;
        @(posedge clk_i);
        #1;
        ulpi_dir_i = d;
        ulpi_nxt_i = n;
        item.tag  = tag;
        item.exp  = e;
        item.rchk = rc;
        item.rexp = re;
        sb.push_back(item);
    endtask

    always @(negedge clk_i) begin : mon
        sb_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, {ulpi_data_o, ulpi_stp_o, reg_ack_o, tx_err_o, tx_ready_o}, e.exp);
            if (e.rchk) chk("rdata", {4'h0, reg_rdata_o}, {4'h0, e.rexp});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        cyc("rst", 0, 0, ex(8'h00, 0, 0, 0, 0), 1, 8'h00);
        rst_i = 1'b1;
        cyc("idle0", 0, 0, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);

        // Register write 0x0A <= 0x55, nxt always high
        cyc("w_pre", 0, 1, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);
        reg_req_i = 1; reg_we_i = 1; reg_addr_i = 6'h0A; reg_wdata_i = 8'h55;
        cyc("w_cmd", 0, 1, ex(8'h8A, 0, 0, 0, 0), 0, 8'h00);
        cyc("w_dat", 0, 1, ex(8'h55, 0, 0, 0, 0), 0, 8'h00);
        cyc("w_stp", 0, 1, ex(8'h00, 1, 1, 0, 0), 0, 8'h00);
        reg_req_i = 0;
        cyc("w_idle", 0, 0, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);

        // Register read 0x04, PHY returns 0x1B
        cyc("r_pre", 0, 0, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);
        reg_req_i = 1; reg_we_i = 0; reg_addr_i = 6'h04;
        cyc("r_cmd", 0, 1, ex(8'hC4, 0, 0, 0, 0), 0, 8'h00);
        cyc("r_turn", 1, 0, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);
        cyc("r_data", 1, 0, ex(8'h00, 0, 0, 0, 0), 1, 8'h00);
        ulpi_data_i = 8'h1B;
        cyc("r_ack", 0, 0, ex(8'h00, 0, 1, 0, 0), 1, 8'h1B);
        reg_req_i = 0; ulpi_data_i = 8'h00;
        cyc("r_hold", 0, 0, ex(8'h00, 0, 0, 0, 0), 1, 8'h1B);

        // TX PID 0xC3, bytes 0x01, 0x02(last), nxt low before each byte
        cyc("t_pre", 0, 0, ex(8'h00, 0, 0, 0, 1), 0, 8'h00);
        tx_valid_i = 1; tx_data_i = 8'hC3; tx_last_i = 0;
        cyc("t_cmd", 0, 0, ex(8'h43, 0, 0, 0, 0), 0, 8'h00);
        tx_data_i = 8'h01;
        cyc("t_cmdh", 0, 1, ex(8'h43, 0, 0, 0, 0), 0, 8'h00);
        cyc("t_w1", 0, 0, ex(8'h43, 0, 0, 0, 0), 0, 8'h00);
        cyc("t_a1", 0, 1, ex(8'h43, 0, 0, 0, 1), 0, 8'h00);
        cyc("t_b1", 0, 0, ex(8'h01, 0, 0, 0, 0), 0, 8'h00);
        tx_data_i = 8'h02; tx_last_i = 1;
        cyc("t_a2", 0, 1, ex(8'h01, 0, 0, 0, 1), 0, 8'h00);
        cyc("t_b2", 0, 0, ex(8'h02, 0, 0, 0, 0), 0, 8'h00);
        tx_valid_i = 0; tx_last_i = 0;
        cyc("t_stp", 0, 0, ex(8'h00, 1, 0, 0, 0), 0, 8'h00);
        cyc("t_idle", 0, 0, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);

        // dir rises during the write command: release, wait for bus-free, retry
        cyc("a_pre", 0, 0, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);
        reg_req_i = 1; reg_we_i = 1; reg_addr_i = 6'h0A; reg_wdata_i = 8'h55;
        cyc("a_cmd", 1, 0, ex(8'h8A, 0, 0, 0, 0), 0, 8'h00);
        cyc("a_rel", 1, 0, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);
        cyc("a_dir0", 0, 0, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);
        cyc("a_free", 0, 0, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);
        cyc("a_cmd2", 0, 1, ex(8'h8A, 0, 0, 0, 0), 0, 8'h00);
        cyc("a_dat", 0, 1, ex(8'h55, 0, 0, 0, 0), 0, 8'h00);
        cyc("a_stp", 0, 1, ex(8'h00, 1, 1, 0, 0), 0, 8'h00);
        reg_req_i = 0;
        cyc("a_idle", 0, 0, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);

        // dir rises after the second data byte of PID 0xA5 + 0x11, 0x22, 0x33
        cyc("x_pre", 0, 1, ex(8'h00, 0, 0, 0, 1), 0, 8'h00);
        tx_valid_i = 1; tx_data_i = 8'hA5; tx_last_i = 0;
        cyc("x_cmd", 0, 1, ex(8'h45, 0, 0, 0, 0), 0, 8'h00);
        tx_data_i = 8'h11;
        cyc("x_a1", 0, 1, ex(8'h45, 0, 0, 0, 1), 0, 8'h00);
        cyc("x_a2", 0, 1, ex(8'h11, 0, 0, 0, 1), 0, 8'h00);
        tx_data_i = 8'h22;
        cyc("x_dir", 1, 0, ex(8'h22, 0, 0, 0, 0), 0, 8'h00);
        tx_data_i = 8'h33; tx_last_i = 1;
        cyc("x_err", 1, 0, ex(8'h00, 0, 0, 1, 1), 0, 8'h00);
        cyc("x_drn", 1, 0, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);
        tx_valid_i = 0; tx_last_i = 0;
        cyc("x_idle", 0, 0, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);
        cyc("x_idle2", 0, 0, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);

        // Simultaneous register write and TX: register first
        cyc("s_pre", 0, 1, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);
        reg_req_i = 1; reg_we_i = 1; reg_addr_i = 6'h11; reg_wdata_i = 8'h3C;
        tx_valid_i = 1; tx_data_i = 8'hD2; tx_last_i = 0;
        cyc("s_cmd", 0, 1, ex(8'h91, 0, 0, 0, 0), 0, 8'h00);
        cyc("s_dat", 0, 1, ex(8'h3C, 0, 0, 0, 0), 0, 8'h00);
        cyc("s_stp", 0, 1, ex(8'h00, 1, 1, 0, 0), 0, 8'h00);
        reg_req_i = 0;
        cyc("s_txi", 0, 1, ex(8'h00, 0, 0, 0, 1), 0, 8'h00);
        cyc("s_cmd2", 0, 1, ex(8'h42, 0, 0, 0, 0), 0, 8'h00);
        tx_data_i = 8'h77; tx_last_i = 1;
        cyc("s_a1", 0, 1, ex(8'h42, 0, 0, 0, 1), 0, 8'h00);
        cyc("s_b1", 0, 0, ex(8'h77, 0, 0, 0, 0), 0, 8'h00);
        tx_valid_i = 0; tx_last_i = 0;
        cyc("s_stp2", 0, 0, ex(8'h00, 1, 0, 0, 0), 1, 8'h1B);
        cyc("s_idle", 0, 0, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);

        // Reset in the middle of a write: outputs drop at once, no stp
        cyc("m_pre", 0, 0, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);
        reg_req_i = 1; reg_we_i = 1; reg_addr_i = 6'h0A; reg_wdata_i = 8'h55;
        cyc("m_cmd", 0, 1, ex(8'h8A, 0, 0, 0, 0), 0, 8'h00);
        cyc("m_rst", 0, 1, ex(8'h00, 0, 0, 0, 0), 1, 8'h00);
        rst_i = 1'b0; reg_req_i = 0;
        cyc("m_hold", 0, 1, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);
        rst_i = 1'b1;
        cyc("m_idle", 0, 0, ex(8'h00, 0, 0, 0, 0), 0, 8'h00);

        @(negedge clk_i);
        #1;
        chk("sb_empty", 12'(sb.size()), 12'h000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
